// File: rtl/mix_columns_iter.sv
// mix_columns_iter
//   Iterative AES MixColumns / InvMixColumns over a full 128-bit state.
//   COLS_PER_CYCLE columns are transformed in place per BUSY cycle, so one
//   block takes N = 4 / COLS_PER_CYCLE cycles. Whole states are exchanged
//   with the neighbouring round stages over valid/ready handshakes.
//
// Ports
//   Clk_CI       clock, rising edge
//   Reset_RBI    asynchronous active-low reset
//   In_DI        input state; column c = In_DI[32c+31:32c], row r at byte r
//   InValid_SI   In_DI / Inverse_SI valid
//   InReady_SO   block can accept a state this cycle
//   Inverse_SI   0 = MixColumns, 1 = InvMixColumns (sampled with In_DI)
//   Out_DO       result state, same layout as In_DI
//   OutValid_SO  Out_DO holds a complete result
//   OutReady_SI  downstream accepts Out_DO
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk_CI,
    input  logic         Reset_RBI,
    input  logic [127:0] In_DI,
    input  logic         InValid_SI,
    output logic         InReady_SO,
    input  logic         Inverse_SI,
    output logic [127:0] Out_DO,
    output logic         OutValid_SO,
    input  logic         OutReady_SI
);

    localparam int         N      = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] K_LAST = 2'(N - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [127:0]  r_s;
    logic          r_m;
    logic [1:0]    r_k;
    logic          r_out_valid;
    logic [127:0]  w_next_s;
    logic          w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, forward or inverse. Inverse multiples are assembled from
    // the 2x/4x/8x xtime chain: 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        logic [1:0]  i0, i1, i2, i3;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (inv) begin
                res[8*r +: 8] = (x8[i0] ^ x4[i0] ^ x2[i0])
                              ^ (x8[i1] ^ x2[i1] ^ a[i1])
                              ^ (x8[i2] ^ x4[i2] ^ a[i2])
                              ^ (x8[i3] ^ a[i3]);
            end else begin
                res[8*r +: 8] = x2[i0] ^ x2[i1] ^ a[i1] ^ a[i2] ^ a[i3];
            end
        end
        return res;
    endfunction

    // Replace only the column group selected by K; other columns pass through.
    always_comb begin
        w_next_s = r_s;
        for (int c = 0; c < 4; c++) begin
            if ((c / COLS_PER_CYCLE) == int'(r_k)) begin
                w_next_s[32*c +: 32] = mix_col(r_s[32*c +: 32], r_m);
            end
        end
    end

    // Ready is combinational from OutReady_SI so a new block can enter on
    // the same edge the previous result leaves.
    assign InReady_SO  = (r_state == IDLE) || ((r_state == DONE) && OutReady_SI);
    assign w_accept    = InValid_SI && InReady_SO;
    assign Out_DO      = r_s;
    assign OutValid_SO = r_out_valid;

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_m         <= 1'b0;
            r_k         <= 2'd0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_s         <= In_DI;
            r_m         <= Inverse_SI;
            r_k         <= 2'd0;
            r_state     <= BUSY;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                BUSY: begin
                    r_s <= w_next_s;
                    if (r_k == K_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                DONE: begin
                    if (OutReady_SI) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;

    logic [127:0] in_d    [3];
    logic         in_v    [3];
    logic         inv     [3];
    logic         out_rdy [3];
    logic         in_rdy  [3];
    logic [127:0] out_d   [3];
    logic         out_v   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [127:0] exp_q [3][$];
    int           acc_q [3][$];
    logic         prev_v   [3];
    logic         prev_rdy [3];
    logic [127:0] prev_d   [3];

    // Column 0: db 13 53 45 -> 8e 4d a1 bc ; column 1: f2 0a 22 5c -> 9f dc 58 9d
    // column 2: 01 01 01 01 -> unchanged ; column 3: d4 d4 d4 d5 -> d5 d5 d7 d6
    localparam logic [127:0] KIN  = 128'hd5d4d4d4_01010101_5c220af2_455313db;
    localparam logic [127:0] KOUT = 128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .In_DI(in_d[0]), .InValid_SI(in_v[0]),
        .InReady_SO(in_rdy[0]), .Inverse_SI(inv[0]), .Out_DO(out_d[0]),
        .OutValid_SO(out_v[0]), .OutReady_SI(out_rdy[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .In_DI(in_d[1]), .InValid_SI(in_v[1]),
        .InReady_SO(in_rdy[1]), .Inverse_SI(inv[1]), .Out_DO(out_d[1]),
        .OutValid_SO(out_v[1]), .OutReady_SI(out_rdy[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .In_DI(in_d[2]), .InValid_SI(in_v[2]),
        .InReady_SO(in_rdy[2]), .Inverse_SI(inv[2]), .Out_DO(out_d[2]),
        .OutValid_SO(out_v[2]), .OutReady_SI(out_rdy[2]));

    function automatic int nv(input int k);
        return 4 >> k;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int k);
        checks++;
        failures++;
        $display("FAIL %s dut%0d t=%0t", nm, k, $time);
    endtask

    // Reference: generic GF(2^8) multiply and the circulant matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic m);
        logic [7:0]   coef [4];
        logic [127:0] o;
        logic [7:0]   acc;
        if (m) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor / scoreboard: observes handshakes on the falling edge, when
    // all inputs for the coming rising edge are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                exp_q[k].delete();
                acc_q[k].delete();
                prev_v[k]   = 1'b0;
                prev_rdy[k] = 1'b0;
                prev_d[k]   = '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (acc_q[k].size() > 0 && !out_v[k])
                    chk("busy_inready", k, in_rdy[k], 0);
                if (prev_v[k] && !prev_rdy[k]) begin
                    chk("hold_valid", k, out_v[k], 1);
                    chk("hold_data", k, out_d[k], prev_d[k]);
                end
                if (out_v[k] && !out_rdy[k])
                    chk("stall_inready", k, in_rdy[k], 0);
                if (out_v[k] && !prev_v[k]) begin
                    if (acc_q[k].size() == 0) fail_now("unexpected_valid", k);
                    else chk("latency", k, cyc - acc_q[k].pop_front(), nv(k));
                end
                if (out_v[k] && out_rdy[k]) begin
                    if (exp_q[k].size() == 0) fail_now("unexpected_output", k);
                    else chk("result", k, out_d[k], exp_q[k].pop_front());
                end
                if (in_v[k] && in_rdy[k]) begin
                    exp_q[k].push_back(model(in_d[k], inv[k]));
                    acc_q[k].push_back(cyc + 1);
                end
                prev_v[k]   = out_v[k];
                prev_rdy[k] = out_rdy[k];
                prev_d[k]   = out_d[k];
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input logic m, output int acc_e);
        int n;
        n = 0;
        in_d[k] = d;
        inv[k]  = m;
        in_v[k] = 1'b1;
        while (!in_rdy[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_rdy[k]) begin
            fail_now("send_timeout", k);
            in_v[k] = 1'b0;
            acc_e   = -1;
            return;
        end
        @(posedge clk); #1;
        in_v[k] = 1'b0;
        acc_e   = cyc;
    endtask

    task automatic wait_out(input int k);
        int n;
        n = 0;
        while (!out_v[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_v[k]) fail_now("wait_out_timeout", k);
    endtask

    initial begin
        int           e, pe;
        logic [127:0] d1, d2, held;
        logic         m;
        for (int k = 0; k < 3; k++) begin
            in_d[k] = '0; in_v[k] = 1'b0; inv[k] = 1'b0; out_rdy[k] = 1'b1;
            prev_v[k] = 1'b0; prev_rdy[k] = 1'b0; prev_d[k] = '0;
        end

        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", k, out_v[k], 0);
            chk("reset_in_ready", k, in_rdy[k], 1);
            chk("reset_out_data", k, out_d[k], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer forward then inverse, all three widths
        for (int k = 0; k < 3; k++) begin
            send(k, KIN, 1'b0, e);
            wait_out(k);
            chk("kat_fwd", k, out_d[k], KOUT);
            send(k, KOUT, 1'b1, e);
            wait_out(k);
            chk("kat_inv", k, out_d[k], KIN);
            @(posedge clk); #1;
        end

        // Constant column is a fixed point in both directions
        for (int k = 0; k < 3; k++) begin
            for (int mm = 0; mm < 2; mm++) begin
                send(k, {16{8'hc6}}, 1'(mm), e);
                wait_out(k);
                chk("const_c6", k, out_d[k], {16{8'hc6}});
                @(posedge clk); #1;
            end
        end

        // Backpressure with a pending input and a toggling mode line
        out_rdy[0] = 1'b0;
        d1 = rand128();
        send(0, d1, 1'b0, e);
        wait_out(0);
        held = out_d[0];
        chk("bp_first", 0, held, model(d1, 1'b0));
        d2 = rand128();
        in_d[0] = d2;
        in_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inv[0] = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_valid", 0, out_v[0], 1);
            chk("bp_data", 0, out_d[0], held);
            chk("bp_inready", 0, in_rdy[0], 0);
        end
        inv[0]     = 1'b1;
        out_rdy[0] = 1'b1;
        #1;
        chk("bp_release_inready", 0, in_rdy[0], 1);
        @(posedge clk); #1;
        in_v[0] = 1'b0;
        wait_out(0);
        chk("bp_mode", 0, out_d[0], model(d2, 1'b1));
        @(posedge clk); #1;

        // Back-to-back streaming, random data and modes
        for (int k = 0; k < 3; k++) begin
            pe = 0;
            for (int i = 0; i < 8; i++) begin
                m = 1'($urandom_range(0, 1));
                send(k, rand128(), m, e);
                if (i > 0) chk("stream_spacing", k, e - pe, nv(k) + 1);
                pe = e;
            end
            wait_out(k);
            @(posedge clk); #1;
        end

        // Reset during BUSY with K=1
        send(0, rand128(), 1'b0, e);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 0, out_v[0], 0);
        chk("midrst_in_ready", 0, in_rdy[0], 1);
        chk("midrst_out_data", 0, out_d[0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_stale", 0, out_v[0], 0);
        end
        d1 = rand128();
        send(0, d1, 1'b1, e);
        wait_out(0);
        chk("post_reset", 0, out_d[0], model(d1, 1'b1));
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            chk("sb_empty", k, exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
